// File: rtl/seqdet_pkg.sv
// Shared types and constants for the run-length sequence detector.
package seqdet_pkg;

    // Encoded FSM state; value is exported on the debug port.
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN0 = 2'b01,
        S_RUN1 = 2'b10
    } seq_state_e;

    // Run-time polarity selection.
    localparam logic [1:0] MODE_ANY  = 2'b00;
    localparam logic [1:0] MODE_ZERO = 2'b01;
    localparam logic [1:0] MODE_ONE  = 2'b10;
    localparam logic [1:0] MODE_OFF  = 2'b11;

    // True when a run of the given polarity qualifies under mode.
    function automatic logic mode_allows(input logic [1:0] mode, input logic pol_one);
        if (pol_one) begin
            return (mode == MODE_ANY) || (mode == MODE_ONE);
        end
        return (mode == MODE_ANY) || (mode == MODE_ZERO);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and a restart-at-one clear.
// clear alone loads 0; clear together with inc loads 1 (a fresh count).
module sat_counter #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned MAX   = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] q,
    output logic             at_max
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Saturation flag decoded from the register.
    always_comb begin
        at_max = (q_q == WIDTH'(MAX));
    end

    // Next count: restart, hold at the ceiling, or step by one.
    always_comb begin
        q_d = q_q;
        if (clear) begin
            q_d = inc ? WIDTH'(1) : '0;
        end else if (inc && !at_max) begin
            q_d = q_q + WIDTH'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/seq_run_detector.sv
// Moore detector for runs of RUN_LEN or more equal samples on w.
// Optional hit counter is built only when SEQDET_HITCNT_EN is defined;
// otherwise hit_count is tied to zero. Valid for HIT_W up to 32.
module seq_run_detector
    import seqdet_pkg::*;
#(
    parameter  int unsigned RUN_LEN = 4,
    parameter  int unsigned HIT_W   = 8,
    localparam int unsigned CNT_W   = $clog2(RUN_LEN + 1)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             en,
    input  logic             w,
    input  logic [1:0]       mode,
    output logic             z,
    output logic             z_zero,
    output logic             z_one,
    output logic [CNT_W-1:0] run_cnt,
    output seq_state_e       state_q,
    output logic [HIT_W-1:0] hit_count
);

    seq_state_e state_d;
    logic       run_clear;
    logic       run_inc;
    logic       run_at_max;

    // State register; reset dominates the sample strobe.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and run-counter control; nothing moves without en.
    always_comb begin
        state_d   = state_q;
        run_clear = 1'b0;
        run_inc   = 1'b0;
        if (en) begin
            unique case (state_q)
                S_IDLE: begin
                    state_d   = w ? S_RUN1 : S_RUN0;
                    run_clear = 1'b1;
                    run_inc   = 1'b1;
                end
                S_RUN0: begin
                    run_inc = 1'b1;
                    if (w) begin
                        state_d   = S_RUN1;
                        run_clear = 1'b1;
                    end
                end
                S_RUN1: begin
                    run_inc = 1'b1;
                    if (!w) begin
                        state_d   = S_RUN0;
                        run_clear = 1'b1;
                    end
                end
                default: begin
                    state_d   = S_IDLE;
                    run_clear = 1'b1;
                end
            endcase
        end
    end

    // Length of the current run, pinned at RUN_LEN.
    sat_counter #(
        .WIDTH (CNT_W),
        .MAX   (RUN_LEN)
    ) u_run_cnt (
        .clk    (Clock),
        .rst    (Reset),
        .clear  (run_clear),
        .inc    (run_inc),
        .q      (run_cnt),
        .at_max (run_at_max)
    );

    // Moore output decode; mode only gates the combined flag.
    always_comb begin
        z_zero = (state_q == S_RUN0) && run_at_max;
        z_one  = (state_q == S_RUN1) && run_at_max;
        z      = (z_zero && mode_allows(mode, 1'b0)) ||
                 (z_one  && mode_allows(mode, 1'b1));
    end

`ifdef SEQDET_HITCNT_EN
    localparam int unsigned HIT_MAX = (HIT_W >= 32) ? 32'hFFFF_FFFF
                                                    : ((32'd1 << HIT_W) - 32'd1);

    logic hit_inc;
    logic hit_at_max;

    // Count a run once, on the sample that first brings it to RUN_LEN.
    always_comb begin
        hit_inc = 1'b0;
        if (en && !hit_at_max && (run_cnt == CNT_W'(RUN_LEN - 1))) begin
            hit_inc = ((state_q == S_RUN0) && !w && mode_allows(mode, 1'b0)) ||
                      ((state_q == S_RUN1) &&  w && mode_allows(mode, 1'b1));
        end
    end

    // Number of qualified runs since reset, saturating.
    sat_counter #(
        .WIDTH (HIT_W),
        .MAX   (HIT_MAX)
    ) u_hit_cnt (
        .clk    (Clock),
        .rst    (Reset),
        .clear  (1'b0),
        .inc    (hit_inc),
        .q      (hit_count),
        .at_max (hit_at_max)
    );
`else
    assign hit_count = '0;
`endif

endmodule

// File: tb/tb_seq_run_detector.sv
// Scoreboard bench for seq_run_detector (RUN_LEN=4, HIT_W=2).
module tb_seq_run_detector;

    localparam logic [1:0] M_ANY  = 2'b00;
    localparam logic [1:0] M_ZERO = 2'b01;
    localparam logic [1:0] M_ONE  = 2'b10;
    localparam logic [1:0] M_OFF  = 2'b11;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       w = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       z, z_zero, z_one;
    logic [2:0] run_cnt;
    logic [1:0] state_q;
    logic [1:0] hit_count;

    typedef struct {
        string      nm;
        logic [1:0] st;
        logic [2:0] cnt;
        logic       zz;
        logic       zo;
        logic       z;
        logic [1:0] hit;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   errors = 0;
    int   checks = 0;

    seq_run_detector #(
        .RUN_LEN (4),
        .HIT_W   (2)
    ) dut (
        .Clock     (clk),
        .Reset     (rst),
        .en        (en),
        .w         (w),
        .mode      (mode),
        .z         (z),
        .z_zero    (z_zero),
        .z_one     (z_one),
        .run_cnt   (run_cnt),
        .state_q   (state_q),
        .hit_count (hit_count)
    );

    always #5 clk = ~clk;

    // Monitor: one expected record per clock edge once stimulus has queued it.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({state_q, run_cnt, z_zero, z_one, z, hit_count} !==
                {e.st, e.cnt, e.zz, e.zo, e.z, e.hit}) begin
                errors++;
                $display("FAIL %s: got st=%0d cnt=%0d zz=%b zo=%b z=%b hit=%0d, want st=%0d cnt=%0d zz=%b zo=%b z=%b hit=%0d",
                         e.nm, state_q, run_cnt, z_zero, z_one, z, hit_count,
                         e.st, e.cnt, e.zz, e.zo, e.z, e.hit);
            end
        end
    end

    // Drive one cycle of inputs and queue the outputs expected after that edge.
    task automatic step(input string nm, input bit r, input bit e_in, input bit w_in,
                        input logic [1:0] m, input int st, input int cnt,
                        input bit zz, input bit zo, input bit zf, input int hit);
        exp_t x;
        @(negedge clk);
        rst  = r;
        en   = e_in;
        w    = w_in;
        mode = m;
        x.nm  = nm;
        x.st  = 2'(st);
        x.cnt = 3'(cnt);
        x.zz  = zz;
        x.zo  = zo;
        x.z   = zf;
`ifdef SEQDET_HITCNT_EN
        x.hit = 2'(hit);
`else
        x.hit = 2'(hit * 0);
`endif
        exp_q.push_back(x);
    endtask

    initial begin
        // nm, rst, en, w, mode, state, cnt, z_zero, z_one, z, hit
        step("reset",      1, 0, 0, M_ANY,  0, 0, 0, 0, 0, 0);
        step("rst_en_win", 1, 1, 1, M_ANY,  0, 0, 0, 0, 0, 0);
        // four zeros, any polarity
        step("z0_1",       0, 1, 0, M_ANY,  1, 1, 0, 0, 0, 0);
        step("z0_2",       0, 1, 0, M_ANY,  1, 2, 0, 0, 0, 0);
        step("z0_3",       0, 1, 0, M_ANY,  1, 3, 0, 0, 0, 0);
        step("z0_4",       0, 1, 0, M_ANY,  1, 4, 1, 0, 1, 1);
        // longer run stays pinned, then polarity flip
        step("z0_5",       0, 1, 0, M_ANY,  1, 4, 1, 0, 1, 1);
        step("z0_6",       0, 1, 0, M_ANY,  1, 4, 1, 0, 1, 1);
        step("z0_7",       0, 1, 0, M_ANY,  1, 4, 1, 0, 1, 1);
        step("flip_1",     0, 1, 1, M_ANY,  2, 1, 0, 0, 0, 1);
        // zeros-only mode ignores a run of ones
        step("m01_o2",     0, 1, 1, M_ZERO, 2, 2, 0, 0, 0, 1);
        step("m01_o3",     0, 1, 1, M_ZERO, 2, 3, 0, 0, 0, 1);
        step("m01_o4",     0, 1, 1, M_ZERO, 2, 4, 0, 1, 0, 1);
        step("m01_o5",     0, 1, 1, M_ZERO, 2, 4, 0, 1, 0, 1);
        step("m01_o6",     0, 1, 1, M_ZERO, 2, 4, 0, 1, 0, 1);
        // mode change mid-run: z follows, no retroactive hit
        step("m00_late",   0, 1, 1, M_ANY,  2, 4, 0, 1, 1, 1);
        step("m11_hold",   0, 0, 0, M_OFF,  2, 4, 0, 1, 0, 1);
        step("m01_z1",     0, 1, 0, M_ZERO, 1, 1, 0, 0, 0, 1);
        step("m01_z2",     0, 1, 0, M_ZERO, 1, 2, 0, 0, 0, 1);
        step("m01_z3",     0, 1, 0, M_ZERO, 1, 3, 0, 0, 0, 1);
        step("m01_z4",     0, 1, 0, M_ZERO, 1, 4, 1, 0, 1, 2);
        // en=0 cycles with toggling w are ignored
        step("en_a1",      0, 1, 1, M_ANY,  2, 1, 0, 0, 0, 2);
        step("en_off_a",   0, 0, 0, M_ANY,  2, 1, 0, 0, 0, 2);
        step("en_a2",      0, 1, 1, M_ANY,  2, 2, 0, 0, 0, 2);
        step("en_off_b",   0, 0, 0, M_ANY,  2, 2, 0, 0, 0, 2);
        step("en_off_c",   0, 0, 1, M_ANY,  2, 2, 0, 0, 0, 2);
        step("en_a3",      0, 1, 1, M_ANY,  2, 3, 0, 0, 0, 2);
        step("en_off_d",   0, 0, 0, M_ANY,  2, 3, 0, 0, 0, 2);
        step("en_a4",      0, 1, 1, M_ANY,  2, 4, 0, 1, 1, 3);
        // reset on the 3rd sample of a run
        step("rr_1",       0, 1, 0, M_ANY,  1, 1, 0, 0, 0, 3);
        step("rr_2",       0, 1, 0, M_ANY,  1, 2, 0, 0, 0, 3);
        step("rr_rst",     1, 1, 0, M_ANY,  0, 0, 0, 0, 0, 0);
        step("rr_new",     0, 1, 0, M_ANY,  1, 1, 0, 0, 0, 0);
        // five detected runs saturate a 2-bit hit counter
        step("s1_2",       0, 1, 0, M_ANY,  1, 2, 0, 0, 0, 0);
        step("s1_3",       0, 1, 0, M_ANY,  1, 3, 0, 0, 0, 0);
        step("s1_4",       0, 1, 0, M_ANY,  1, 4, 1, 0, 1, 1);
        step("s2_1",       0, 1, 1, M_ANY,  2, 1, 0, 0, 0, 1);
        step("s2_2",       0, 1, 1, M_ANY,  2, 2, 0, 0, 0, 1);
        step("s2_3",       0, 1, 1, M_ANY,  2, 3, 0, 0, 0, 1);
        step("s2_4",       0, 1, 1, M_ANY,  2, 4, 0, 1, 1, 2);
        step("s3_1",       0, 1, 0, M_ANY,  1, 1, 0, 0, 0, 2);
        step("s3_2",       0, 1, 0, M_ANY,  1, 2, 0, 0, 0, 2);
        step("s3_3",       0, 1, 0, M_ANY,  1, 3, 0, 0, 0, 2);
        step("s3_4",       0, 1, 0, M_ANY,  1, 4, 1, 0, 1, 3);
        step("s4_1",       0, 1, 1, M_ANY,  2, 1, 0, 0, 0, 3);
        step("s4_2",       0, 1, 1, M_ANY,  2, 2, 0, 0, 0, 3);
        step("s4_3",       0, 1, 1, M_ANY,  2, 3, 0, 0, 0, 3);
        step("s4_4",       0, 1, 1, M_ANY,  2, 4, 0, 1, 1, 3);
        step("s5_1",       0, 1, 0, M_ANY,  1, 1, 0, 0, 0, 3);
        step("s5_2",       0, 1, 0, M_ANY,  1, 2, 0, 0, 0, 3);
        step("s5_3",       0, 1, 0, M_ANY,  1, 3, 0, 0, 0, 3);
        step("s5_4",       0, 1, 0, M_ANY,  1, 4, 1, 0, 1, 3);
        // ones-only and disabled modes after reset
        step("m_rst",      1, 0, 0, M_ONE,  0, 0, 0, 0, 0, 0);
        step("m10_z1",     0, 1, 0, M_ONE,  1, 1, 0, 0, 0, 0);
        step("m10_z2",     0, 1, 0, M_ONE,  1, 2, 0, 0, 0, 0);
        step("m10_z3",     0, 1, 0, M_ONE,  1, 3, 0, 0, 0, 0);
        step("m10_z4",     0, 1, 0, M_ONE,  1, 4, 1, 0, 0, 0);
        step("m11_o1",     0, 1, 1, M_OFF,  2, 1, 0, 0, 0, 0);
        step("m11_o2",     0, 1, 1, M_OFF,  2, 2, 0, 0, 0, 0);
        step("m11_o3",     0, 1, 1, M_OFF,  2, 3, 0, 0, 0, 0);
        step("m11_o4",     0, 1, 1, M_OFF,  2, 4, 0, 1, 0, 0);
        step("m10_o5",     0, 1, 1, M_ONE,  2, 4, 0, 1, 1, 0);

        // Drain the scoreboard within a bounded number of cycles.
        @(negedge clk);
        en = 1'b0;
        for (int i = 0; i < 8 && exp_q.size() > 0; i++) begin
            @(negedge clk);
        end
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending records, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_run_detector.md
# seq_run_detector

Parametrised Moore sequence detector that flags a run of RUN_LEN or more consecutive identical samples on a serial input. It generalises the fixed four-in-a-row lab detector: run length is a parameter, the target polarity is selectable at run time, and a sample-enable allows a free-running clock. An optional saturating counter records how many distinct runs have been detected. The block sits between a debounced switch/serial source and the LEDR/HEX display logic on the lab board.

## Interface
- RUN_LEN, 4, number of consecutive equal samples that constitutes a detection; legal range 2..255
- HIT_W, 8, width of the detected-run counter
- CNT_W, $clog2(RUN_LEN+1), derived local parameter; width of the run counter; not overridable

- Clock  in  1  single clock; all state changes on posedge
- Reset  in  1  synchronous, active-high; dominates every other input
- en  in  1  sample strobe; w is consumed only on cycles with en=1
- w  in  1  serial data sample
- mode  in  2  00 = either polarity, 01 = runs of 0 only, 10 = runs of 1 only, 11 = detection disabled
- z  out  1  detection flag (Moore; function of registered state and mode)
- z_zero  out  1  a run of ≥RUN_LEN zeros is active
- z_one  out  1  a run of ≥RUN_LEN ones is active
- run_cnt  out  CNT_W  length of the current run, saturating at RUN_LEN
- state_q  out  2  encoded FSM state, intended for LEDR debug
- hit_count  out  HIT_W  number of detected runs since reset

## Operation
- FSM states: S_IDLE (no sample since reset), S_RUN0 (current run is zeros), S_RUN1 (current run is ones).
- With en=1: S_IDLE → S_RUN0/S_RUN1 according to w, run_cnt←1. Same polarity as the current run: stay, run_cnt←min(run_cnt+1, RUN_LEN). Opposite polarity: switch state, run_cnt←1.
- With en=0: all state, run_cnt and hit_count hold.
- z_zero = (state==S_RUN0 && run_cnt==RUN_LEN); z_one = (state==S_RUN1 && run_cnt==RUN_LEN). Both are independent of mode.
- z = (z_zero && mode∈{00,01}) || (z_one && mode∈{00,10}). z=0 whenever mode=11.
- A run longer than RUN_LEN keeps z high and run_cnt pinned at RUN_LEN. The counter never wraps.
- hit_count increments by 1 on the cycle in which run_cnt first reaches RUN_LEN in a state that mode currently qualifies. It is one count per run, not one per sample, and saturates at 2^HIT_W−1.
- Changing mode mid-run changes z combinationally on the next evaluation. It does not retroactively count a run that is already at saturation.

## Timing
- Reset values: state_q=S_IDLE (2'b00), run_cnt=0, z=z_zero=z_one=0, hit_count=0.
- Latency: the RUN_LEN-th qualifying sample is captured at edge k, and z is high from just after edge k. z is a decode of registers with no additional pipeline stage.
- z falls after the first edge that captures an opposite-polarity sample with en=1.
- Reset asserted mid-run: all registers return to their reset values at that edge, regardless of en/w. The next en=1 sample starts a new run of length 1.
- Reset and en are asserted on the same edge: reset wins and the sample is discarded.

## Configuration
- SEQDET_HITCNT_EN defined: the hit counter is implemented as described above.
- SEQDET_HITCNT_EN undefined: no hit-counter flops are synthesised, and hit_count is driven constant 0. All other behaviour is identical.

## Structure
- Shared package seqdet_pkg holds:
  - the state enum S_IDLE=2'b00, S_RUN0=2'b01, S_RUN1=2'b10
  - the mode constants MODE_ANY, MODE_ZERO, MODE_ONE, MODE_OFF
- Sub-module sat_counter (parameters WIDTH and MAX; ports clear, inc, q, at_max) is used for both run_cnt and hit_count.
- The top level contains the next-state logic, the output decode, and the `ifdef around the hit-counter instance.

## Test plan
- Reset, then en=1 with w=0,0,0,0 (RUN_LEN=4, mode=00) → run_cnt 1,2,3,4; z and z_zero rise after the 4th edge; hit_count=1.
- Continue with w=0 ×3, then w=1 → z stays 1 and run_cnt stays 4 during the zeros; after the w=1 edge z=0, state_q=S_RUN1, run_cnt=1; hit_count remains 1.
- mode=01 with w=1 ×5 → z_one=1, z=0, hit_count unchanged; then w=0 ×4 → z=1, hit_count+1.
- Interleave en=0 cycles with toggling w inside a 1,1,1,1 sequence → toggles ignored; z rises after the 4th en=1 edge only.
- Assert Reset on the edge of the 3rd sample of a run with en=1 → all outputs return to 0; the next sample gives run_cnt=1.
- HIT_W=2 with 5 separate detected runs → hit_count saturates at 3. With SEQDET_HITCNT_EN undefined, the same stimulus gives hit_count=0 throughout and identical z behaviour.
